regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports a_valid/a_ready  input/output  1/1  ALU write-back handshake.
REQ-006 SHALL have ports a_addr/a_data  input  ADDR_W/DATA_W  ALU destination index and result.
REQ-007 SHALL have ports b_valid/b_ready  input/output  1/1  load (memory) write-back handshake.
REQ-008 SHALL have ports b_addr/b_data  input  ADDR_W/DATA_W  load destination index and data.
REQ-009 SHALL have ports reg_write, write_register, write_data  output  1/ADDR_W/DATA_W  register bank write port.
REQ-010 SHALL have port busy  output  1  high while any holding entry is full.
REQ-011 SHALL have ports read_register1/read_register2  input  ADDR_W  forwarding lookup indices.
REQ-012 SHALL have ports fwd_hit1/fwd_hit2, fwd_data1/fwd_data2  output  1/DATA_W  forwarding results.

Function
REQ-013 SHALL hold one entry per requester (HA, HB): full bit, addr, data, age bit.
REQ-014 SHALL transfer on a requester when valid && ready at a rising edge.
REQ-015 SHALL drive x_ready = !Hx.full || (Hx granted this cycle); entry drained and reloaded on the same edge.
REQ-016 SHALL accept transfers with addr 0 but SHALL NOT load the entry; they are discarded, register 0 is never written.
REQ-017 SHALL grant at most one full entry per cycle; reg_write = 1 iff a grant exists; write_register/write_data = granted entry; all three combinational from held state.
REQ-018 SHALL, with one entry full, grant that entry.
REQ-019 SHALL, with both full and equal addr, grant the older entry (age ordering).
REQ-020 SHALL, with both full and different addr, grant round-robin: the requester not granted last; pointer updates only on a grant.
REQ-021 SHALL set age on load: entry loaded while the other is full and not draining is younger; both loaded on the same edge -> HB older.
REQ-022 SHALL clear the full bit of the granted entry at the edge; the register bank captures the write at that same edge.
REQ-023 SHALL give latency: accepted at edge N -> reg_write high during cycle N..N+1 -> bank updated at edge N+1 when uncontended; worst case edge N+2.
REQ-024 SHALL drive busy = HA.full || HB.full.

Reset
REQ-025 SHALL on rst high immediately clear both full bits and age bits, set the round-robin pointer to "B last" (A wins the first contention).
REQ-026 SHALL during reset drive reg_write=0, write_register=0, write_data=0, busy=0, a_ready=1, b_ready=1, fwd_hit1/2=0, fwd_data1/2=0.
REQ-027 SHALL drop held entries when reset asserts mid-operation; no partial write is issued.

Configuration
REQ-028 SHALL compile forwarding only when macro REGFILE_WB_FWD_EN is defined.
REQ-029 SHALL, with REGFILE_WB_FWD_EN, drive fwd_hitN=1 and fwd_dataN=entry data when read_registerN != 0 matches a full entry; if both match, the younger entry wins; combinational.
REQ-030 SHALL, without REGFILE_WB_FWD_EN, tie fwd_hit1/2 and fwd_data1/2 to 0; read_register1/2 unused.

Verification
REQ-031 SHALL test single ALU write: a_valid, a_addr=3, a_data=0x0000_00AA one cycle -> next cycle reg_write=1, write_register=3, write_data=0xAA; busy=0 after.
REQ-032 SHALL test contention: A(addr 4, 0x11) and B(addr 5, 0x22) same edge -> A written first, B next cycle; repeat -> B first.
REQ-033 SHALL test WAW ordering: B(addr 7, 0x1) held, A(addr 7, 0x2) accepted while B full -> writes 0x1 then 0x2 to reg 7.
REQ-034 SHALL test addr 0: b_valid, b_addr=0, b_data=0xFFFF_FFFF -> b_ready=1, no reg_write, busy=0.
REQ-035 SHALL test mid-operation reset: both entries full, rst pulse -> reg_write=0, busy=0, ready=1 immediately, no write after release.
REQ-036 SHALL test forwarding (macro defined): HA holds addr 9 data 0x55, read_register1=9 -> fwd_hit1=1, fwd_data1=0x55; undefined -> fwd_hit1=0.

Source files
------------

// File: rtl/regfile_wb_if.sv
// Write-back bus between the two requesters (ALU, load unit), the register
// bank write port and the forwarding lookup. The arbiter attaches as slave.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              busy;
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  read_register1, read_register2,
    output a_ready, b_ready, reg_write, write_register, write_data, busy,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output read_register1, read_register2,
    input  a_ready, b_ready, reg_write, write_register, write_data, busy,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one holding entry per requester (A = ALU,
// B = load unit), one register bank write per cycle. Same-destination entries
// drain oldest first; otherwise round-robin. Writes to register 0 are dropped.
// Optional forwarding lookup out of the held entries: define REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);

  logic              ha_full_q, ha_full_d;
  logic [ADDR_W-1:0] ha_addr_q, ha_addr_d;
  logic [DATA_W-1:0] ha_data_q, ha_data_d;
  logic              ha_old_q,  ha_old_d;
  logic              hb_full_q, hb_full_d;
  logic [ADDR_W-1:0] hb_addr_q, hb_addr_d;
  logic [DATA_W-1:0] hb_data_q, hb_data_d;
  logic              hb_old_q,  hb_old_d;
  logic              rr_last_b_q, rr_last_b_d;

  logic grant_a, grant_b;
  logic a_load, b_load;

  // Pick at most one full entry: age decides same-destination pairs, else round-robin.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (ha_full_q && hb_full_q) begin
      if (ha_addr_q == hb_addr_q) grant_a = ha_old_q;
      else                        grant_a = rr_last_b_q;
      grant_b = !grant_a;
    end else begin
      grant_a = ha_full_q;
      grant_b = hb_full_q;
    end
  end

  // An entry can accept when empty or when it is being drained this cycle.
  assign bus.a_ready = !ha_full_q || grant_a;
  assign bus.b_ready = !hb_full_q || grant_b;

  // Transfers to register 0 complete the handshake but never occupy an entry.
  assign a_load = bus.a_valid && bus.a_ready && (bus.a_addr != '0);
  assign b_load = bus.b_valid && bus.b_ready && (bus.b_addr != '0);

  assign bus.reg_write      = grant_a || grant_b;
  assign bus.write_register = grant_a ? ha_addr_q : (grant_b ? hb_addr_q : '0);
  assign bus.write_data     = grant_a ? ha_data_q : (grant_b ? hb_data_q : '0);
  assign bus.busy           = ha_full_q || hb_full_q;

  // Next state: drain the granted entry, reload on accept, track age and round-robin.
  always_comb begin
    ha_full_d   = ha_full_q && !grant_a;
    ha_addr_d   = ha_addr_q;
    ha_data_d   = ha_data_q;
    hb_full_d   = hb_full_q && !grant_b;
    hb_addr_d   = hb_addr_q;
    hb_data_d   = hb_data_q;
    ha_old_d    = ha_old_q;
    hb_old_d    = hb_old_q;
    rr_last_b_d = rr_last_b_q;

    if (a_load) begin
      ha_full_d = 1'b1;
      ha_addr_d = bus.a_addr;
      ha_data_d = bus.a_data;
    end
    if (b_load) begin
      hb_full_d = 1'b1;
      hb_addr_d = bus.b_addr;
      hb_data_d = bus.b_data;
    end

    // A freshly loaded entry is younger than one still held; a simultaneous
    // load of both makes B the older, which is the same outcome as A alone.
    if (a_load) begin
      ha_old_d = 1'b0;
      hb_old_d = 1'b1;
    end else if (b_load) begin
      ha_old_d = 1'b1;
      hb_old_d = 1'b0;
    end

    if (grant_a || grant_b) rr_last_b_d = grant_b;
  end

  // State registers; reset drops any held entry so no partial write escapes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ha_full_q   <= 1'b0;
      ha_addr_q   <= '0;
      ha_data_q   <= '0;
      ha_old_q    <= 1'b0;
      hb_full_q   <= 1'b0;
      hb_addr_q   <= '0;
      hb_data_q   <= '0;
      hb_old_q    <= 1'b0;
      rr_last_b_q <= 1'b1;
    end else begin
      ha_full_q   <= ha_full_d;
      ha_addr_q   <= ha_addr_d;
      ha_data_q   <= ha_data_d;
      ha_old_q    <= ha_old_d;
      hb_full_q   <= hb_full_d;
      hb_addr_q   <= hb_addr_d;
      hb_data_q   <= hb_data_d;
      hb_old_q    <= hb_old_d;
      rr_last_b_q <= rr_last_b_d;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  // Lookup of a non-zero index in the held entries; the younger entry wins a double hit.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0] idx,
    input logic              a_full, b_full, a_old,
    input logic [ADDR_W-1:0] a_addr, b_addr,
    input logic [DATA_W-1:0] a_data, b_data
  );
    logic hit_a, hit_b;
    hit_a = a_full && (idx != '0) && (a_addr == idx);
    hit_b = b_full && (idx != '0) && (b_addr == idx);
    if (hit_a && hit_b) fwd_lookup = {1'b1, (a_old ? b_data : a_data)};
    else if (hit_a)     fwd_lookup = {1'b1, a_data};
    else if (hit_b)     fwd_lookup = {1'b1, b_data};
    else                fwd_lookup = '0;
  endfunction

  // Forwarding port 1.
  always_comb begin
    {bus.fwd_hit1, bus.fwd_data1} = fwd_lookup(bus.read_register1, ha_full_q, hb_full_q,
                                               ha_old_q, ha_addr_q, hb_addr_q,
                                               ha_data_q, hb_data_q);
  end

  // Forwarding port 2.
  always_comb begin
    {bus.fwd_hit2, bus.fwd_data2} = fwd_lookup(bus.read_register2, ha_full_q, hb_full_q,
                                               ha_old_q, ha_addr_q, hb_addr_q,
                                               ha_data_q, hb_data_q);
  end
`else
  logic unused_read_regs;
  assign unused_read_regs = ^{bus.read_register1, bus.read_register2};
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = '0;
  assign bus.fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a table of one-cycle injections
// from idle plus hand sequences (write-after-write, forwarding, mid-op reset).
// Expected bank writes are queued when stimulus is driven and popped by a
// monitor whenever reg_write is seen.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    int            n;
    logic [AW-1:0] e0a;
    logic [DW-1:0] e0d;
    logic [AW-1:0] e1a;
    logic [DW-1:0] e1d;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[9];
  int   tests = 0;
  int   fails = 0;

`ifdef REGFILE_WB_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
  endtask

  // Advance to just after a rising edge until the queue is drained and the arbiter idle.
  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && bus.busy == 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, {63'd0, done}, 64'd1);
  endtask

  // Scoreboard: every bank write seen must be the next expected one.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {59'd0, bus.write_register}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {59'd0, bus.write_register}, {59'd0, e.addr});
        check("wr_data", {32'd0, bus.write_data}, {32'd0, e.data});
        $display("[TB] write reg %0d data 0x%08h", bus.write_register, bus.write_data);
      end
    end
  end

  initial begin
    // {a_valid, a_addr, a_data, b_valid, b_addr, b_data, n_writes, 1st, 2nd}
    vecs[0] = '{1'b1, 5'd4,  32'h11,       1'b1, 5'd5,  32'h22,       2, 5'd4,  32'h11,       5'd5,  32'h22};
    vecs[1] = '{1'b1, 5'd3,  32'hAA,       1'b0, 5'd0,  32'h0,        1, 5'd3,  32'hAA,       5'd0,  32'h0};
    vecs[2] = '{1'b1, 5'd4,  32'h11,       1'b1, 5'd5,  32'h22,       2, 5'd5,  32'h22,       5'd4,  32'h11};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h66,       1, 5'd6,  32'h66,       5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd8,  32'h123,      1'b1, 5'd9,  32'h456,      2, 5'd8,  32'h123,      5'd9,  32'h456};
    vecs[5] = '{1'b1, 5'd7,  32'h2,        1'b1, 5'd7,  32'h1,        2, 5'd7,  32'h1,        5'd7,  32'h2};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,        5'd0,  32'h0};
    vecs[7] = '{1'b1, 5'd0,  32'h5,        1'b1, 5'd10, 32'hBB,       1, 5'd10, 32'hBB,       5'd0,  32'h0};
    vecs[8] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1, 5'd31, 32'hDEADBEEF, 5'd0,  32'h0};

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    bus.read_register1 = '0;
    bus.read_register2 = '0;

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
    check("rst_write_register", {59'd0, bus.write_register}, 64'd0);
    check("rst_write_data", {32'd0, bus.write_data}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_a_ready", {63'd0, bus.a_ready}, 64'd1);
    check("rst_b_ready", {63'd0, bus.b_ready}, 64'd1);
    check("rst_fwd_hit1", {63'd0, bus.fwd_hit1}, 64'd0);
    check("rst_fwd_data1", {32'd0, bus.fwd_data1}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table: one-cycle injection from idle, expected writes in order.
    for (int r = 0; r < 9; r++) begin
      drive(vecs[r].av, vecs[r].aa, vecs[r].ad, vecs[r].bv, vecs[r].ba, vecs[r].bd);
      if (vecs[r].n > 0) push(vecs[r].e0a, vecs[r].e0d);
      if (vecs[r].n > 1) push(vecs[r].e1a, vecs[r].e1d);
      @(negedge clk);
      check("row_a_ready", {63'd0, bus.a_ready}, 64'd1);
      check("row_b_ready", {63'd0, bus.b_ready}, 64'd1);
      @(posedge clk);
      #1;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      check("row_busy", {63'd0, bus.busy}, {63'd0, vecs[r].n > 0});
      @(negedge clk);
      check("row_latency", {63'd0, bus.reg_write}, {63'd0, vecs[r].n > 0});
      wait_idle("row");
      $display("[TB] row %0d applied: a_valid=%0b a_addr=%0d b_valid=%0b b_addr=%0d writes=%0d",
               r, vecs[r].av, vecs[r].aa, vecs[r].bv, vecs[r].ba, vecs[r].n);
    end

    // Write-after-write: B(7,1) held while A(7,2) is accepted; reg 7 gets 1 then 2.
    drive(1'b0, '0, '0, 1'b1, 5'd15, 32'h15);
    push(5'd15, 32'h15);
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    wait_idle("waw_prep");
    drive(1'b1, 5'd20, 32'h9, 1'b1, 5'd7, 32'h1);
    push(5'd20, 32'h9);
    push(5'd7, 32'h1);
    push(5'd7, 32'h2);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd7, 32'h2, 1'b0, '0, '0);
    check("waw_a_ready_on_drain", {63'd0, bus.a_ready}, 64'd1);
    check("waw_b_ready_held", {63'd0, bus.b_ready}, 64'd0);
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check("waw_busy", {63'd0, bus.busy}, 64'd1);
    wait_idle("waw");
    $display("[TB] waw sequence on reg 7 applied");

    // Forwarding: both entries hold reg 9, A (younger) supplies the data.
    drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 32'h66);
    push(5'd9, 32'h66);
    push(5'd9, 32'h55);
    bus.read_register1 = 5'd9;
    bus.read_register2 = 5'd0;
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    check("fwd_hit1_both", {63'd0, bus.fwd_hit1}, {63'd0, FWD});
    check("fwd_data1_both", {32'd0, bus.fwd_data1}, FWD ? 64'h55 : 64'h0);
    check("fwd_hit2_zero_idx", {63'd0, bus.fwd_hit2}, 64'd0);
    @(posedge clk);
    #1;
    bus.read_register2 = 5'd9;
    #1;
    check("fwd_hit1_a_only", {63'd0, bus.fwd_hit1}, {63'd0, FWD});
    check("fwd_data1_a_only", {32'd0, bus.fwd_data1}, FWD ? 64'h55 : 64'h0);
    check("fwd_hit2_a_only", {63'd0, bus.fwd_hit2}, {63'd0, FWD});
    check("fwd_data2_a_only", {32'd0, bus.fwd_data2}, FWD ? 64'h55 : 64'h0);
    wait_idle("fwd");
    check("fwd_hit1_empty", {63'd0, bus.fwd_hit1}, 64'd0);
    bus.read_register1 = '0;
    bus.read_register2 = '0;
    $display("[TB] forwarding sequence on reg 9 applied");

    // Reset with both entries full: outputs clear at once, nothing written afterwards.
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    @(posedge clk);
    #1;
    check("mid_busy_before", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_reg_write", {63'd0, bus.reg_write}, 64'd0);
    check("mid_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_a_ready", {63'd0, bus.a_ready}, 64'd1);
    check("mid_b_ready", {63'd0, bus.b_ready}, 64'd1);
    check("mid_write_data", {32'd0, bus.write_data}, 64'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy_after", {63'd0, bus.busy}, 64'd0);
    $display("[TB] mid-operation reset applied");

    // Round-robin pointer is back to A-first after reset.
    drive(1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22);
    push(5'd4, 32'h11);
    push(5'd5, 32'h22);
    @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    wait_idle("post_rst");
    $display("[TB] post-reset contention applied");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
